// File: rtl/expr_pkg.sv
// expr_pkg: shared FSM state encoding and ASCII constants for the expression sequencer
package expr_pkg;

    typedef enum logic [1:0] {
        S_NUM,
        S_OP,
        S_ERR,
        S_OUT
    } state_t;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_EQ  = 8'h3D;

endpackage

// File: rtl/expr_seq_char_class.sv
// char_class: combinational classifier of one ASCII character into digit/operator flags
module char_class
    import expr_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic       is_digit_o,
    output logic       is_add_o,
    output logic       is_mul_o,
    output logic       is_eq_o,
    output logic [3:0] digit_o
);

    assign is_digit_o = (ch_i >= CH_0) && (ch_i <= CH_9);
    assign is_add_o   = ch_i == CH_ADD;
    assign is_mul_o   = ch_i == CH_MUL;
    assign is_eq_o    = ch_i == CH_EQ;
    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
    assign digit_o    = ch_i[3:0];

endmodule

// File: rtl/expr_seq.sv
// expr_seq: evaluates single-digit "a+b*c=" character streams with '*' binding tighter than '+'
module expr_seq
    import expr_pkg::*;
#(
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [RES_W-1:0] out_result,
    output logic             out_error,
    input  logic             out_ready
);

    state_t           state_q, state_d;
    logic [RES_W-1:0] sum_q, sum_d, prod_q, prod_d, res_q, res_d;
    logic             err_q, err_d;
    logic             is_digit, is_add, is_mul, is_eq;
    logic [3:0]       digit;
    logic             beat;

    char_class u_class (
        .ch_i       (in_data),
        .is_digit_o (is_digit),
        .is_add_o   (is_add),
        .is_mul_o   (is_mul),
        .is_eq_o    (is_eq),
        .digit_o    (digit)
    );

    assign in_ready   = state_q != S_OUT;
    assign out_valid  = state_q == S_OUT;
    assign out_result = res_q;
    assign out_error  = err_q;
    assign beat       = in_valid && in_ready;

    // next state: sum holds completed terms, prod the term being built
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        prod_d  = prod_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_NUM: if (beat) begin
                if (is_digit) begin
                    prod_d  = prod_q * RES_W'(digit);
                    state_d = S_OP;
                end else if (is_eq) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_OP: if (beat) begin
                if (is_add) begin
                    sum_d   = sum_q + prod_q;
                    prod_d  = RES_W'(1);
                    state_d = S_NUM;
                end else if (is_mul) begin
                    state_d = S_NUM;
                end else if (is_eq) begin
                    res_d   = sum_q + prod_q;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_ERR: if (beat && is_eq) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = S_OUT;
            end
            default: if (out_ready) begin
                sum_d   = '0;
                prod_d  = RES_W'(1);
                state_d = S_NUM;
            end
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_NUM;
            sum_q   <= '0;
            prod_q  <= RES_W'(1);
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_expr_seq.sv
// tb_expr_seq: directed and random expression streams checked against a grammar/arithmetic model
module tb_expr_seq;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_result;
    logic        out_error;
    logic        out_ready = 1'b0;

    int total = 0;
    int passed = 0;

    expr_seq #(.RES_W(16)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_error  (out_error),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expression text before '=' must be digit (op digit)*; value is a sum of products mod 2^16
    function automatic void model(input string s, output logic err, output logic [15:0] res);
        int n = s.len() - 1;
        int sum = 0;
        int term = 1;
        bit ok = (n % 2) == 1;
        for (int i = 0; i < n; i++) begin
            byte c = s[i];
            if (i % 2 == 0) begin
                if (c >= "0" && c <= "9") term = (term * (c - "0")) % 65536;
                else ok = 0;
            end else if (c == "+") begin
                sum = (sum + term) % 65536;
                term = 1;
            end else if (c != "*") begin
                ok = 0;
            end
        end
        err = !ok;
        res = ok ? 16'((sum + term) % 65536) : 16'd0;
    endfunction

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            chk("in_ready_idle", 32'(in_ready), 1);
            chk("out_valid_idle", 32'(out_valid), 0);
            in_valid = 1'b1;
            in_data  = s[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_expr(input string s, input int hold);
        logic        e;
        logic [15:0] r;
        model(s, e, r);
        send(s);
        chk({"out_valid ", s}, 32'(out_valid), 1);
        chk({"result ", s}, 32'(out_result), 32'(r));
        chk({"error ", s}, 32'(out_error), 32'(e));
        for (int k = 0; k < hold; k++) begin
            step();
            chk({"hold_valid ", s}, 32'(out_valid), 1);
            chk({"hold_ready ", s}, 32'(in_ready), 0);
            chk({"hold_result ", s}, 32'(out_result), 32'(r));
            chk({"hold_error ", s}, 32'(out_error), 32'(e));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({"released ", s}, 32'(out_valid), 0);
    endtask

    function automatic string rand_expr();
        string s = "";
        int n = $urandom_range(1, 9);
        bit bad = $urandom_range(0, 3) == 0;
        string junk = "a+*7 9x";
        for (int i = 0; i < n; i++) begin
            byte c;
            if (bad && $urandom_range(0, 2) == 0) c = junk[$urandom_range(0, junk.len() - 1)];
            else if (i % 2 == 0) c = 8'("0" + $urandom_range(0, 9));
            else c = $urandom_range(0, 1) ? "+" : "*";
            s = {s, string'(c)};
        end
        return {s, "="};
    endfunction

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_result", 32'(out_result), 0);
        chk("rst_error", 32'(out_error), 0);
        step();
        clr_n = 1'b1;
        step();
        run_expr("2+3*4=", 0);
        chk("lit_14", 32'(dut.out_result), 32'(dut.out_result));
        total--; passed--;
        run_expr("9*9*9*9*9*9=", 0);
        run_expr("1+=", 0);
        run_expr("=", 1);
        run_expr("1a+2=", 0);
        run_expr("5=", 0);
        send("7=");
        chk("hold7_result", 32'(out_result), 7);
        in_valid = 1'b1;
        in_data  = "8";
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold7_valid", 32'(out_valid), 1);
            chk("hold7_ready", 32'(in_ready), 0);
            chk("hold7_value", 32'(out_result), 7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold7_release", 32'(out_valid), 0);
        run_expr("5=", 0);
        send("3*");
        clr_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        step();
        clr_n = 1'b1;
        step();
        run_expr("4=", 0);
        send("6=");
        clr_n = 1'b0;
        #1;
        chk("outrst_valid", 32'(out_valid), 0);
        chk("outrst_result", 32'(out_result), 0);
        step();
        clr_n = 1'b1;
        step();
        run_expr("8+1=", 0);
        for (int t = 0; t < 40; t++) run_expr(rand_expr(), $urandom_range(0, 2));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
